multi_phase_sig_control: RTL and testbench

Parametrised N-phase traffic signal controller, successor to the two-road main/sub controller. Drives one RED/YELLOW/GREEN light pair per approach.
- Phase 0 is the main road and the rest phase.
- Phases are served round-robin on latched vehicle demand.
- Min/max green, yellow and all-red intervals are cycle-accurate counters, not delay statements.
- Adds a night flash mode.

---
 rtl/sig_pkg.sv | 6 +
 rtl/rr_phase_arb.sv | 25 ++
 rtl/multi_phase_sig_control.sv | 101 ++++++++++
 tb/tb_multi_phase_sig_control.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sig_pkg.sv
// sig_pkg: light encodings, controller states and phase-index width shared by signal blocks
package sig_pkg;
  localparam int PHASE_W = 3;
  localparam logic [1:0] RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2;
  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_t;
endpackage

// File: rtl/rr_phase_arb.sv
// rr_phase_arb: picks the nearest requesting phase after cur_i (cur_i itself last), 0 if none
module rr_phase_arb
  import sig_pkg::*;
#(
  parameter int N_PHASE = 2
) (
  input  logic [N_PHASE-1:0] req_i,
  input  logic [PHASE_W-1:0] cur_i,
  output logic [PHASE_W-1:0] nxt_o
);
  always_comb begin
    int best, d;
    best = N_PHASE + 1;
    d = 0;
    nxt_o = '0;
    for (int j = 0; j < N_PHASE; j++) begin
      d = (j - int'(cur_i) + N_PHASE) % N_PHASE;
      d = (d == 0) ? N_PHASE : d;
      if (req_i[j] && d < best) begin
        best = d;
        nxt_o = PHASE_W'(j);
      end
    end
  end
endmodule

// File: rtl/multi_phase_sig_control.sv
// multi_phase_sig_control: N-phase signal controller, round-robin service on latched demand,
// phase 0 rest/recall, cycle-counted intervals and night flash; all outputs registered
module multi_phase_sig_control
  import sig_pkg::*;
#(
  parameter int N_PHASE = 2,
  parameter int TW = 8,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int FLASH_HALF = 8
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [N_PHASE-1:0]   X,
  input  logic                 flash_en,
  output logic [2*N_PHASE-1:0] lights,
  output logic [PHASE_W-1:0]   cur_phase,
  output logic                 busy_clr
);
  localparam int LW = 2 * N_PHASE;
  localparam logic [TW-1:0] MIN_T = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_T = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_T = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AR_T = TW'(ALLRED_TIME - 1);
  localparam logic [TW-1:0] FL_T = TW'(FLASH_HALF - 1);

  state_t state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d, nxt;
  logic [TW-1:0] timer_q, timer_d;
  logic [N_PHASE-1:0] req_q, req_d, arb_req, own;
  logic [LW-1:0] lights_q, lights_d;
  logic tog_q, tog_d, fl_q, fl_d, busy_q, busy_d;
  logic other, xp, min_ok, max_ok, entry;

  rr_phase_arb #(.N_PHASE(N_PHASE)) u_arb (.req_i(arb_req), .cur_i(phase_q), .nxt_o(nxt));

  always_comb begin
    own = N_PHASE'(1) << phase_q;
    arb_req = req_q | X | N_PHASE'(phase_q != '0);
    other = |(req_q & ~own) | (phase_q != '0);
    xp = |(X & own);
    min_ok = timer_q >= MIN_T;
    max_ok = timer_q >= MAX_T;
    state_d = state_q;
    phase_d = phase_q;
    tog_d = tog_q;
    fl_d = fl_q;
    unique case (state_q)
      S_GREEN:  state_d = (min_ok && (flash_en || (other && (!xp || max_ok)))) ? S_YELLOW : S_GREEN;
      S_YELLOW: state_d = (timer_q == YEL_T) ? S_ALLRED : S_YELLOW;
      S_ALLRED: if (timer_q == AR_T) begin
        state_d = flash_en ? S_FLASH : S_GREEN;
        phase_d = flash_en ? phase_q : fl_q ? '0 : nxt;
        fl_d = 1'b0;
      end
      S_FLASH: begin
        state_d = flash_en ? S_FLASH : S_ALLRED;
        fl_d = !flash_en;
        tog_d = tog_q ^ (timer_q == FL_T);
      end
    endcase
    entry = state_d != state_q;
    tog_d = (entry && state_d == S_FLASH) ? 1'b0 : tog_d;
    timer_d = (entry || (state_q == S_FLASH && timer_q == FL_T)) ? '0 : (&timer_q ? timer_q : timer_q + 1'b1);
    // a sensor still high on the grant edge re-latches on the following edge
    req_d = (req_q | X) & ~((entry && state_d == S_GREEN) ? (N_PHASE'(1) << phase_d) : '0);
    busy_d = state_d == S_YELLOW || state_d == S_ALLRED;
    lights_d = '0;
    for (int i = 0; i < N_PHASE; i++)
      lights_d[2*i +: 2] = (phase_d == PHASE_W'(i) && state_d == S_GREEN) ? GREEN :
                           (phase_d == PHASE_W'(i) && state_d == S_YELLOW) ? YELLOW :
                           (i == 0 && state_d == S_FLASH && tog_d) ? YELLOW : RED;
  end

  always_ff @(posedge clock)
    if (clear) begin
      state_q <= S_GREEN;
      phase_q <= '0;
      timer_q <= '0;
      req_q <= '0;
      tog_q <= 1'b0;
      fl_q <= 1'b0;
      busy_q <= 1'b0;
      lights_q <= LW'(GREEN);
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
      req_q <= req_d;
      tog_q <= tog_d;
      fl_q <= fl_d;
      busy_q <= busy_d;
      lights_q <= lights_d;
    end

  assign lights = lights_q;
  assign cur_phase = phase_q;
  assign busy_clr = busy_q;
endmodule

// File: tb/tb_multi_phase_sig_control.sv
// tb_multi_phase_sig_control: vector table, corner sequences and random traffic against a reference model
module tb_multi_phase_sig_control;
  localparam int N = 3, MIN_G = 4, MAX_G = 10, YT = 2, AT = 1, FH = 8;
  localparam int GO = 0, AMBER = 1, CLEARANCE = 2, NIGHT = 3;

  logic clock = 1'b0, clear = 1'b1, flash_en = 1'b0;
  logic [N-1:0] X = '0;
  logic [2*N-1:0] lights;
  logic [2:0] cur_phase;
  logic busy_clr;

  multi_phase_sig_control #(.N_PHASE(N)) dut (
    .clock(clock), .clear(clear), .X(X), .flash_en(flash_en),
    .lights(lights), .cur_phase(cur_phase), .busy_clr(busy_clr)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int m_mode = GO, m_own = 0, m_age = 0;
  bit [N-1:0] m_pend = '0;
  bit m_night_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit [N-1:0] want, input int from);
    for (int k = 1; k <= N; k++)
      if (want[(from + k) % N] || ((from + k) % N == 0 && from != 0)) return (from + k) % N;
    return 0;
  endfunction

  task automatic model_step();
    int nm, no, el;
    bit opp;
    if (clear) begin
      m_mode = GO; m_own = 0; m_age = 0; m_pend = '0; m_night_done = 1'b0;
      return;
    end
    nm = m_mode; no = m_own; el = m_age + 1;
    opp = m_own != 0;
    for (int j = 0; j < N; j++) if (j != m_own && m_pend[j]) opp = 1'b1;
    if (m_mode == GO) begin
      if (el >= MIN_G && (flash_en || (opp && (!X[m_own] || el >= MAX_G)))) nm = AMBER;
    end else if (m_mode == AMBER) begin
      if (el == YT) nm = CLEARANCE;
    end else if (m_mode == CLEARANCE) begin
      if (el == AT) begin
        if (flash_en) nm = NIGHT;
        else begin
          nm = GO;
          no = m_night_done ? 0 : pick(m_pend | X, m_own);
        end
        m_night_done = 1'b0;
      end
    end else if (!flash_en) begin
      nm = CLEARANCE;
      m_night_done = 1'b1;
    end
    m_pend |= X;
    if (nm == GO && m_mode != GO) m_pend[no] = 1'b0;
    m_age = (nm != m_mode) ? 0 : m_age + 1;
    m_mode = nm;
    m_own = no;
  endtask

  function automatic logic [2*N-1:0] exp_lights();
    logic [2*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (i == m_own && m_mode == GO) v[2*i +: 2] = 2'd2;
      else if (i == m_own && m_mode == AMBER) v[2*i +: 2] = 2'd1;
    if (m_mode == NIGHT && (m_age / FH) % 2 == 1) v[1:0] = 2'd1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("model_lights", lights, exp_lights());
    check("model_phase", cur_phase, m_own);
    check("model_busy", busy_clr, (m_mode == AMBER || m_mode == CLEARANCE));
  endtask

  task automatic do_reset();
    clear = 1'b1; X = '0; flash_en = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  typedef struct {
    bit clr;
    bit [N-1:0] x;
    logic [2*N-1:0] lt;
    int ph;
    bit bz;
  } vec_t;
  vec_t tbl[20];

  initial begin
    int g, viol;
    bit pb, fl_state;
    int q[$];
    // row k drives the inputs seen on edge k and holds the outputs of cycle k
    for (int k = 0; k < 20; k++) begin
      tbl[k].clr = (k == 0);
      tbl[k].x = (k == 1) ? 3'b010 : 3'b000;
      tbl[k].lt = (k < 4) ? 6'h02 : (k < 6) ? 6'h01 : (k < 7) ? 6'h00 :
                  (k < 11) ? 6'h08 : (k < 13) ? 6'h04 : (k < 14) ? 6'h00 : 6'h02;
      tbl[k].ph = (k >= 7 && k < 14) ? 1 : 0;
      tbl[k].bz = (k >= 4 && k < 7) || (k >= 11 && k < 14);
    end
    for (int k = 0; k < 20; k++) begin
      clear = tbl[k].clr; X = tbl[k].x; flash_en = 1'b0;
      tick();
      check("tbl_lights", lights, tbl[k].lt);
      check("tbl_phase", cur_phase, tbl[k].ph);
      check("tbl_busy", busy_clr, tbl[k].bz);
    end

    // phase 1 held high against recall: max-out
    do_reset();
    X = 3'b010;
    for (int n = 0; n < 40 && lights[3:2] != 2'd2; n++) tick();
    check("maxout_reach_g1", lights[3:2], 2);
    g = 0;
    for (int n = 0; n < 40 && lights[3:2] == 2'd2; n++) begin g++; tick(); end
    check("maxout_green_cycles", g, MAX_G);
    check("maxout_yellow", lights[3:2], 1);
    X = '0;
    for (int n = 0; n < 20 && lights[1:0] != 2'd2; n++) tick();
    check("maxout_next_phase", cur_phase, 0);

    // rest with no demand
    do_reset();
    viol = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (lights !== 6'h02 || busy_clr !== 1'b0) viol++;
    end
    check("rest_violations", viol, 0);

    // round robin from phase 2
    do_reset();
    X = 3'b100; tick(); X = '0;
    for (int n = 0; n < 40 && lights[5:4] != 2'd2; n++) tick();
    check("rr_g2", cur_phase, 2);
    X = 3'b110; tick(); X = '0;
    pb = busy_clr;
    for (int n = 0; n < 120 && q.size() < 2; n++) begin
      tick();
      if (pb && !busy_clr) q.push_back(int'(cur_phase));
      pb = busy_clr;
    end
    check("rr_grants", q.size(), 2);
    check("rr_first", q.size() > 0 ? q[0] : -1, 0);
    check("rr_second", q.size() > 1 ? q[1] : -1, 1);

    // night flash from rest
    do_reset();
    for (int n = 0; n < 9; n++) tick();
    flash_en = 1'b1;
    tick(); check("fl_yellow", lights, 6'h01);
    tick(); tick(); check("fl_allred_busy", busy_clr, 1);
    tick(); check("fl_enter_red", lights, 6'h00); check("fl_enter_busy", busy_clr, 0);
    for (int n = 0; n < 8; n++) tick();
    check("fl_blink_on", lights, 6'h01);
    for (int n = 0; n < 8; n++) tick();
    check("fl_blink_off", lights, 6'h00);
    flash_en = 1'b0;
    tick(); check("fl_exit_allred", busy_clr, 1);
    tick(); check("fl_exit_green", lights, 6'h02); check("fl_exit_phase", cur_phase, 0);

    // clear in the middle of phase 2 yellow
    do_reset();
    X = 3'b100; tick(); X = '0;
    for (int n = 0; n < 40 && lights[5:4] != 2'd2; n++) tick();
    X = 3'b010; tick(); X = '0;
    for (int n = 0; n < 40 && lights[5:4] != 2'd1; n++) tick();
    check("clr_in_yellow", lights[5:4], 1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_lights", lights, 6'h02);
    check("clr_phase", cur_phase, 0);
    check("clr_busy", busy_clr, 0);
    for (int n = 0; n < 15; n++) tick();
    check("clr_req_dropped", lights, 6'h02);

    // random traffic, flash and occasional clear
    do_reset();
    fl_state = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) fl_state = !fl_state;
      flash_en = fl_state;
      X = N'($urandom & $urandom & $urandom);
      clear = ($urandom_range(0, 499) == 0);
      tick();
    end
    clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
